// File: rtl/jellyvl_multiplier_unsigned_multicycle.sv
// Shift-and-add unsigned multiply-accumulate (A*B+C), one multiplicand bit per enabled cycle.
// Result valid MULTIPLICAND_WIDTH enabled cycles after acceptance; s_ready stays low until the result is taken.
module jellyvl_multiplier_unsigned_multicycle #(
  parameter int MULTIPLICAND_WIDTH = 32,
  parameter int MULTIPLIER_WIDTH   = 32,
  parameter int ADDEND_WIDTH       = MULTIPLIER_WIDTH,
  parameter int PRODUCT_WIDTH      = MULTIPLICAND_WIDTH + MULTIPLIER_WIDTH
) (
  input  logic                          reset,
  input  logic                          clk,
  input  logic                          cke,
  input  logic [MULTIPLICAND_WIDTH-1:0] s_multiplicand,
  input  logic [MULTIPLIER_WIDTH-1:0]   s_multiplier,
  input  logic [ADDEND_WIDTH-1:0]       s_addend,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [PRODUCT_WIDTH-1:0]      m_product,
  output logic                          m_valid,
  input  logic                          m_ready
);

  localparam int FULL_WIDTH = MULTIPLIER_WIDTH + MULTIPLICAND_WIDTH;
  localparam int CNT_CLOG   = $clog2(MULTIPLICAND_WIDTH + 1);
  localparam int CNT_WIDTH  = (CNT_CLOG < 1) ? 1 : CNT_CLOG;

  generate
    if (ADDEND_WIDTH > MULTIPLIER_WIDTH) begin : g_addend_width_check
      $error("ADDEND_WIDTH must not exceed MULTIPLIER_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                        state;
  state_t                        state_next;
  logic [MULTIPLIER_WIDTH-1:0]   mcand;
  logic [MULTIPLIER_WIDTH-1:0]   acc_hi;
  logic [MULTIPLICAND_WIDTH-1:0] acc_lo;
  logic [CNT_WIDTH-1:0]          cnt;
  logic [MULTIPLIER_WIDTH:0]     sum;
  logic [FULL_WIDTH-1:0]         shifted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (cke) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (s_valid) state_next = BUSY;
      BUSY:    if (cnt == CNT_WIDTH'(1)) state_next = DONE;
      DONE:    if (m_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign s_ready = (state == IDLE);
  assign m_valid = (state == DONE);

  // Carry out of the partial sum lands in the MSB of acc_hi after the shift.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    shifted = FULL_WIDTH'({sum, acc_lo} >> 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (cke) begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            mcand  <= s_multiplier;
            acc_hi <= MULTIPLIER_WIDTH'(s_addend);
            acc_lo <= s_multiplicand;
            cnt    <= CNT_WIDTH'(MULTIPLICAND_WIDTH);
          end
        end
        BUSY: begin
          {acc_hi, acc_lo} <= shifted;
          cnt              <= cnt - CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign m_product = PRODUCT_WIDTH'({acc_hi, acc_lo});

endmodule

// File: tb/tb_jellyvl_multiplier_unsigned_multicycle.sv
// Directed and randomized checks of the multicycle multiply-accumulate at three width configurations.
module tb_jellyvl_multiplier_unsigned_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        cke     [3];
  logic        s_valid [3];
  logic        m_ready [3];
  logic [31:0] a [3];
  logic [31:0] b [3];
  logic [31:0] c [3];
  wire  [2:0]  s_ready;
  wire  [2:0]  m_valid;
  wire  [1:0]  p0;
  wire  [12:0] p1;
  wire  [63:0] p2;

  int checks = 0;
  int errors = 0;
  int mcw_t [3] = '{1, 8, 32};
  int mw_t  [3] = '{1, 5, 32};
  int aw_t  [3] = '{1, 3, 32};

  always #5 clk = ~clk;

  jellyvl_multiplier_unsigned_multicycle #(
    .MULTIPLICAND_WIDTH(1), .MULTIPLIER_WIDTH(1), .ADDEND_WIDTH(1)
  ) u_dut0 (
    .reset(reset), .clk(clk), .cke(cke[0]),
    .s_multiplicand(a[0][0:0]), .s_multiplier(b[0][0:0]), .s_addend(c[0][0:0]),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .m_product(p0), .m_valid(m_valid[0]), .m_ready(m_ready[0])
  );

  jellyvl_multiplier_unsigned_multicycle #(
    .MULTIPLICAND_WIDTH(8), .MULTIPLIER_WIDTH(5), .ADDEND_WIDTH(3)
  ) u_dut1 (
    .reset(reset), .clk(clk), .cke(cke[1]),
    .s_multiplicand(a[1][7:0]), .s_multiplier(b[1][4:0]), .s_addend(c[1][2:0]),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .m_product(p1), .m_valid(m_valid[1]), .m_ready(m_ready[1])
  );

  jellyvl_multiplier_unsigned_multicycle u_dut (
    .reset(reset), .clk(clk), .cke(cke[2]),
    .s_multiplicand(a[2]), .s_multiplier(b[2]), .s_addend(c[2]),
    .s_valid(s_valid[2]), .s_ready(s_ready[2]),
    .m_product(p2), .m_valid(m_valid[2]), .m_ready(m_ready[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] prod(input int i);
    case (i)
      0:       return 64'(p0);
      1:       return 64'(p1);
      default: return p2;
    endcase
  endfunction

  function automatic logic [31:0] msk32(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [63:0] msk64(input int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Directed helpers act on the default-width instance.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tbv, input logic [31:0] tc);
    @(negedge clk);
    a[2] = ta; b[2] = tbv; c[2] = tc; s_valid[2] = 1'b1;
    check("s_ready_idle", 64'(s_ready[2]), 64'd1);
    @(negedge clk);
    s_valid[2] = 1'b0;
    check("s_ready_busy", 64'(s_ready[2]), 64'd0);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!m_valid[2] && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish_op();
    m_ready[2] = 1'b1;
    @(negedge clk);
    m_ready[2] = 1'b0;
    check("m_valid_drop", 64'(m_valid[2]), 64'd0);
    check("s_ready_back", 64'(s_ready[2]), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                        input logic [31:0] tc, input logic [63:0] exp);
    int n;
    start_op(ta, tbv, tc);
    wait_valid(n);
    check({tag, "_lat"}, 64'(n), 64'd32);
    check({tag, "_prod"}, p2, exp);
    finish_op();
  endtask

  task automatic run_random(input int i, input int cycles);
    logic [63:0] q[$];
    logic [63:0] e;
    logic [63:0] pm;
    logic [31:0] d;
    logic [31:0] nn;
    int nin;
    int nout;
    nin = 0; nout = 0; e = '0;
    pm = msk64(mcw_t[i] + mw_t[i]);
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(negedge clk);
      if (cyc >= cycles - 300) begin
        cke[i] = 1'b1; s_valid[i] = 1'b0; m_ready[i] = 1'b1;
      end else begin
        cke[i]     = ($urandom_range(0, 3) != 0);
        s_valid[i] = ($urandom_range(0, 1) == 1);
        m_ready[i] = ($urandom_range(0, 2) != 0);
        if (i == 2 && $urandom_range(0, 1) == 1) begin
          // Operands taken from a division: q*d + r must rebuild the dividend.
          d = $urandom;
          if (d == 0) d = 32'd1;
          nn = $urandom;
          a[i] = nn / d; b[i] = d; c[i] = nn % d;
          e = 64'(nn);
        end else begin
          a[i] = $urandom & msk32(mcw_t[i]);
          b[i] = $urandom & msk32(mw_t[i]);
          c[i] = $urandom & msk32(aw_t[i]);
          e = (64'(a[i]) * 64'(b[i]) + 64'(c[i])) & pm;
        end
      end
      if (cke[i] && m_valid[i] && m_ready[i]) begin
        nout++;
        check($sformatf("rnd%0d_outq", i), 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) check($sformatf("rnd%0d_prod", i), prod(i), q.pop_front());
      end
      if (cke[i] && s_valid[i] && s_ready[i]) begin
        q.push_back(e);
        nin++;
      end
    end
    check($sformatf("rnd%0d_lost", i), 64'(q.size()), 64'd0);
    check($sformatf("rnd%0d_count", i), 64'(nout), 64'(nin));
    check($sformatf("rnd%0d_active", i), 64'(nin > 20), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int en;
    int chg;
    int seen;
    logic        c_at_edge;
    logic [63:0] old_p;
    logic        old_v;

    for (int i = 0; i < 3; i++) begin
      cke[i] = 1'b1; s_valid[i] = 1'b0; m_ready[i] = 1'b0;
      a[i] = '0; b[i] = '0; c[i] = '0;
    end
    reset = 1'b1;
    #12;
    check("rst_s_ready", 64'(s_ready[2]), 64'd1);
    check("rst_m_valid", 64'(m_valid[2]), 64'd0);
    check("rst_product", p2, 64'd0);
    reset = 1'b0;

    run_op("basic", 32'h0000_008E, 32'd7, 32'd6, 64'd1000);
    run_op("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000);
    run_op("a_zero", 32'h0, 32'h1234_5678, 32'h0000_ABCD, 64'h0000_ABCD);
    run_op("b_zero", 32'hFFFF_FFFF, 32'h0, 32'h0, 64'd0);

    // Output back-pressure with a competing request waiting.
    start_op(32'd10, 32'd20, 32'd3);
    wait_valid(n);
    check("bp_lat", 64'(n), 64'd32);
    a[2] = 32'd2; b[2] = 32'd5; c[2] = 32'd1; s_valid[2] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_m_valid", 64'(m_valid[2]), 64'd1);
      check("bp_s_ready", 64'(s_ready[2]), 64'd0);
      check("bp_prod", p2, 64'd203);
    end
    m_ready[2] = 1'b1;
    @(negedge clk);
    m_ready[2] = 1'b0;
    check("bp_rel_m_valid", 64'(m_valid[2]), 64'd0);
    check("bp_rel_s_ready", 64'(s_ready[2]), 64'd1);
    @(negedge clk);
    s_valid[2] = 1'b0;
    check("bp_accept", 64'(s_ready[2]), 64'd0);
    wait_valid(n);
    check("bp2_lat", 64'(n), 64'd32);
    check("bp2_prod", p2, 64'd11);
    finish_op();

    // Clock enable toggled every cycle.
    start_op(32'd5, 32'd3, 32'd1);
    cke[2] = 1'b0;
    en = 0; chg = 0; n = 0;
    while (!m_valid[2] && n < 200) begin
      c_at_edge = cke[2]; old_p = p2; old_v = m_valid[2];
      @(negedge clk);
      n++;
      if (c_at_edge) en++;
      else if (p2 !== old_p || m_valid[2] !== old_v) chg++;
      cke[2] = ~cke[2];
    end
    cke[2] = 1'b1;
    check("cke_enabled_cycles", 64'(en), 64'd32);
    check("cke_hold", 64'(chg), 64'd0);
    check("cke_prod", p2, 64'd16);
    finish_op();

    // Asynchronous reset in the middle of an operation.
    start_op(32'h0000_FFFF, 32'h0000_1234, 32'd1);
    repeat (9) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_m_valid", 64'(m_valid[2]), 64'd0);
    check("arst_s_ready", 64'(s_ready[2]), 64'd1);
    check("arst_product", p2, 64'd0);
    #1;
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_valid[2]) seen++;
    end
    check("arst_no_output", 64'(seen), 64'd0);
    run_op("post_rst", 32'd2, 32'd3, 32'd0, 64'd6);

    fork
      run_random(0, 20000);
      run_random(1, 20000);
      run_random(2, 20000);
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
